// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and restoring divide, one bit per cycle,
// producing {hi,lo} after a fixed WIDTH+1 edges with a done/div_zero handshake.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic is_div, neg_q, neg_r, sgn_a, sgn_b, dz;
   logic [WIDTH-1:0] mag_b, quo, rem;
   logic [2*WIDTH-1:0] acc, mul_next, div_next;
   logic [WIDTH:0] sum, diff;
   always_comb begin
      sgn_a = ~op[0] & a[WIDTH-1];
      sgn_b = ~op[0] & b[WIDTH-1];
      dz = op[1] & (b == '0);
      // mult: low half holds the remaining multiplier bits; div: {remainder, dividend}
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
      mul_next = {sum, acc[WIDTH-1:1]};
      diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
      div_next = diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      quo = acc[WIDTH-1:0];
      rem = acc[2*WIDTH-1:WIDTH];
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = (state == IDLE) ? ((start && !dz) ? ITER : IDLE) :
                 (state == ITER) ? ((cnt == LAST) ? FIX : ITER) : IDLE;
   end
   always_comb begin
      busy = (state != IDLE);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         is_div <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         mag_b <= '0;
         acc <= '0;
         hi <= '0;
         lo <= '0;
         done <= 1'b0;
         div_zero <= 1'b0;
      end else begin
         done <= (state == FIX) || (state == IDLE && start && dz);
         div_zero <= state == IDLE && start && dz;
         if (state == IDLE && start) begin
            cnt <= '0;
            is_div <= op[1];
            neg_q <= sgn_a ^ sgn_b;
            neg_r <= sgn_a;
            mag_b <= sgn_b ? -b : b;
            acc <= {{WIDTH{1'b0}}, (sgn_a ? -a : a)};
         end
         if (state == ITER) begin
            cnt <= cnt + 1'b1;
            acc <= is_div ? div_next : mul_next;
         end
         if (state == FIX)
            {hi, lo} <= is_div ? {(neg_r ? -rem : rem), (neg_q ? -quo : quo)} : (neg_q ? -acc : acc);
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors, corner sequences and random ops against an arithmetic model.
module tb_muldiv_unit;
   localparam int W = 32;
   logic clk = 0, reset = 1, start = 0;
   logic [1:0] op = 0;
   logic [W-1:0] a = 0, b = 0;
   logic busy, done, div_zero;
   logic [W-1:0] hi, lo;
   int total = 0, bad = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] op;
      logic [31:0] a, b, hi, lo;
      logic dz;
   } vec_t;
   vec_t v[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic go(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; start = 1;
      @(posedge clk);
      #1 start = 0;
   endtask

   // edges counted after the one that sampled start; busy samples taken before done
   task automatic wait_done(output int lat, output int bc);
      lat = 0; bc = 0;
      while (!done && lat < 100) begin
         if (busy) bc++;
         @(posedge clk);
         #1 lat++;
      end
      if (!done) chk("timeout", {63'b0, done}, 64'd1);
   endtask

   function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [63:0] prev);
      longint sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o == 2'd0) begin
         p = 64'(sx * sy);
         return {1'b0, p};
      end
      if (o == 2'd1) begin
         p = {32'b0, x} * {32'b0, y};
         return {1'b0, p};
      end
      if (y == 0) return {1'b1, prev};
      if (o == 2'd2) begin
         q = sx / sy;
         r = sx % sy;
         return {1'b0, 32'(r), 32'(q)};
      end
      return {1'b0, x % y, x / y};
   endfunction

   initial begin
      int lat, bc, n;
      logic [64:0] e;
      logic [63:0] prev;
      logic [1:0] o;
      logic [31:0] x, y;
      v[0] = '{2'd0, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      v[1] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      v[2] = '{2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      v[3] = '{2'd3, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0};
      v[4] = '{2'd2, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0};
      v[5] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0};
      v[6] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0};
      v[7] = '{2'd3, 32'h692, 32'h20, 32'h12, 32'h34, 1'b0};
      v[8] = '{2'd3, 32'd5, 32'd0, 32'h12, 32'h34, 1'b1};
      v[9] = '{2'd2, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0};

      #2;
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_done", {63'b0, done}, 64'd0);
      chk("rst_dz", {63'b0, div_zero}, 64'd0);
      chk("rst_hilo", {hi, lo}, 64'd0);
      @(negedge clk) reset = 0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         go(v[i].op, v[i].a, v[i].b);
         wait_done(lat, bc);
         chk($sformatf("v%0d_hi", i), {32'b0, hi}, {32'b0, v[i].hi});
         chk($sformatf("v%0d_lo", i), {32'b0, lo}, {32'b0, v[i].lo});
         chk($sformatf("v%0d_dz", i), {63'b0, div_zero}, {63'b0, v[i].dz});
         chk($sformatf("v%0d_lat", i), 64'(lat), v[i].dz ? 64'd0 : 64'd33);
         chk($sformatf("v%0d_busycyc", i), 64'(bc), v[i].dz ? 64'd0 : 64'd33);
         chk($sformatf("v%0d_busy_at_done", i), {63'b0, busy}, 64'd0);
         @(posedge clk);
         #1 chk($sformatf("v%0d_done_width", i), {63'b0, done}, 64'd0);
      end

      // back-to-back: start accepted in the done cycle
      @(negedge clk);
      go(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_done(lat, bc);
      chk("b2b_first", {hi, lo}, 64'hFFFFFFFE_00000001);
      go(2'd0, 32'h80000000, 32'h80000000);
      chk("b2b_accepted", {63'b0, busy}, 64'd1);
      wait_done(lat, bc);
      chk("b2b_lat", 64'(lat), 64'd33);
      chk("b2b_second", {hi, lo}, 64'h40000000_00000000);

      // operand change and start re-pulse mid-operation are ignored
      @(negedge clk);
      go(2'd0, 32'd1234, 32'hFFFFFFFB);
      repeat (5) @(posedge clk);
      #1 a = 32'd99; b = 32'd77; op = 2'd3; start = 1;
      @(posedge clk);
      #1 start = 0;
      wait_done(lat, bc);
      chk("ign_lat", 64'(lat), 64'd27);
      e = model(2'd0, 32'd1234, 32'hFFFFFFFB, 64'd0);
      chk("ign_result", {hi, lo}, e[63:0]);
      n = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (done) n++;
      end
      chk("ign_extra_done", 64'(n), 64'd0);

      // asynchronous reset mid-operation
      @(negedge clk);
      go(2'd0, $urandom, $urandom);
      repeat (9) @(posedge clk);
      #2 reset = 1;
      #1;
      chk("arst_busy", {63'b0, busy}, 64'd0);
      chk("arst_done", {63'b0, done}, 64'd0);
      chk("arst_hilo", {hi, lo}, 64'd0);
      @(negedge clk) reset = 0;
      n = 0;
      repeat (40) begin
         @(posedge clk);
         #1 if (done) n++;
      end
      chk("arst_no_done", 64'(n), 64'd0);

      // random operations against the model
      prev = 64'd0;
      for (int i = 0; i < 150; i++) begin
         o = 2'($urandom_range(3));
         x = ($urandom_range(9) == 0) ? 32'h80000000 : $urandom;
         n = $urandom_range(7);
         y = (n == 0) ? 32'd0 : (n == 1) ? 32'hFFFFFFFF : (n == 2) ? 32'($urandom_range(15)) : $urandom;
         e = model(o, x, y, prev);
         @(negedge clk);
         go(o, x, y);
         wait_done(lat, bc);
         chk($sformatf("rnd%0d_op%0d_%h_%h", i, o, x, y), {hi, lo}, e[63:0]);
         chk($sformatf("rnd%0d_dz", i), {63'b0, div_zero}, {63'b0, e[64]});
         chk($sformatf("rnd%0d_lat", i), 64'(lat), e[64] ? 64'd0 : 64'd33);
         prev = e[63:0];
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit that replaces the separate mult and div blocks in the multicycle datapath. It takes operands from the A/B registers and one start pulse from Unid_Control. It produces the HI/LO results and a single done/div_zero handshake. It also adds signed/unsigned modes and a generic operand width.

Parameters:
WIDTH, 32, operand width in bits; hi and lo are each WIDTH bits; must be >= 2.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  multiplicand / dividend
b  input  WIDTH  multiplier / divisor
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when a result (or div-by-zero) completes
div_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with b == 0
hi  output  WIDTH  MULT: upper product half; DIV: remainder
lo  output  WIDTH  MULT: lower product half; DIV: quotient

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, div_zero = 0; hi, lo = 0; internal counter and accumulators = 0.
- States: IDLE, ITER, FIX.
- IDLE:
  - start=1 at edge E0: latch op, sign flags and operand magnitudes (two's-complement absolute value for signed ops, raw value for unsigned ops).
  - Clear counter; go to ITER; busy=1.
  - Later changes on a/b/op are ignored until the operation completes.
- Divide by zero: DIV/DIVU with b==0 at E0 does not enter ITER.
  - After E0: done=1 and div_zero=1 for one cycle; busy stays 0.
  - hi/lo keep their previous values.
- ITER: one bit per cycle for exactly WIDTH edges (E1..E_WIDTH).
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division on magnitudes.
  - Counter width is clog2(WIDTH)+1.
  - After E_WIDTH, go to FIX.
- FIX (edge E_WIDTH+1): apply sign correction and write hi/lo. Then busy=0, done=1 for exactly one cycle, state=IDLE.
  - MULT: {hi,lo} = full 2*WIDTH signed product.
  - MULTU: {hi,lo} = full 2*WIDTH unsigned product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
  - Signed overflow: -2^(WIDTH-1) / -1 gives lo = -2^(WIDTH-1) (wraps), hi = 0, no flag.
  - DIVU: unsigned quotient and remainder.
- Latency: done is visible in the cycle after edge E_WIDTH+1, i.e. WIDTH+1 edges after start was sampled (33 for WIDTH=32). Latency is fixed and does not depend on the data.
- hi/lo change only at the FIX edge and hold between operations.
- start while busy=1 is ignored and does not queue.
- start in the cycle where done=1 (state IDLE) is accepted normally; back-to-back throughput is one op per WIDTH+2 cycles.
- done and div_zero are never asserted outside their single-cycle pulse; div_zero=1 implies done=1.
- Reset mid-operation aborts immediately. No done pulse is produced. hi/lo go to 0.

Test Plan:
1. WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses exactly 33 edges after start, one cycle wide; busy high for the 32 ITER cycles plus the FIX cycle.
2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; then back-to-back MULT a=0x80000000, b=0x80000000 with start in the done cycle -> hi=0x40000000, lo=0.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1; DIV a=7, b=0xFFFFFFFE (-2) -> lo=0xFFFFFFFD, hi=1.
4. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0; DIVU with the same operands -> lo=0, hi=0x80000000.
5. hi=0x12, lo=0x34 from a prior op, then DIVU b=0 -> done=1 and div_zero=1 one edge after start, busy never 1, hi/lo still 0x12/0x34; a following DIV 9/4 gives lo=2, hi=1.
6. MULT started; a/b changed and start re-pulsed at iteration 5 -> result uses the original operands and only one done pulse occurs; a new op is started and reset is asserted asynchronously at iteration 10 -> busy, done, hi, lo go to 0 without waiting for a clock, and no done pulse follows.
